// File: rtl/vga_pixel_writer.sv
// vga_pixel_writer: buffers a plot/x/y/colour pixel stream, converts it to the
// frame-buffer colour depth and linear address, and writes it to memory with a
// ready handshake. Also fills the whole screen with a background colour on request.
module vga_pixel_writer #(
  parameter string       RESOLUTION  = "160x120",
  parameter int unsigned COLOR_DEPTH = 9,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ADDR_W      = 15,
  localparam int unsigned XRES = (RESOLUTION == "640x480") ? 640 :
                                 (RESOLUTION == "320x240") ? 320 : 160,
  localparam int unsigned YRES = (RESOLUTION == "640x480") ? 480 :
                                 (RESOLUTION == "320x240") ? 240 : 120,
  localparam int unsigned NX   = (RESOLUTION == "640x480") ? 10 :
                                 (RESOLUTION == "320x240") ? 9 : 8
) (
  input  logic                   CLOCK_50,
  input  logic                   Resetn,
  input  logic                   plot,
  input  logic [NX-1:0]          VGA_X,
  input  logic [NX-2:0]          VGA_Y,
  input  logic [23:0]            VGA_COLOR,
  input  logic                   clear,
  input  logic [23:0]            bg_color,
  input  logic                   mem_ready,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [COLOR_DEPTH-1:0] mem_data,
  output logic                   busy,
  output logic                   clear_done,
  output logic                   overflow
);

  localparam int unsigned C  = COLOR_DEPTH / 3;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(XRES * YRES - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]      fifo_addr [FIFO_DEPTH];
  logic [COLOR_DEPTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count_q, count_d;
  logic [ADDR_W-1:0]      clr_cnt, clr_cnt_d;
  logic [COLOR_DEPTH-1:0] bg_q;

  logic                   we_d, done_d, busy_d, pop;
  logic [ADDR_W-1:0]      addr_d;
  logic [COLOR_DEPTH-1:0] data_d;
  logic [PW-1:0]          rd_sel;

  logic                   in_range, enq, complete, avail;
  logic [ADDR_W-1:0]      pix_addr;

  // Truncate each 8-bit channel to its C most significant bits.
  function automatic logic [COLOR_DEPTH-1:0] to_depth(input logic [23:0] c);
    return {c[23 -: C], c[15 -: C], c[7 -: C]};
  endfunction

  // Low colour bits are dropped by design.
  logic unused_color;
  assign unused_color = ^{VGA_COLOR, bg_color};

  // Input qualification and address generation.
  always_comb begin
    in_range = (32'(VGA_X) < XRES) && (32'(VGA_Y) < YRES);
    pix_addr = ADDR_W'(VGA_Y) * ADDR_W'(XRES) + ADDR_W'(VGA_X);
    enq      = plot && in_range && !busy;
    complete = mem_we && mem_ready;
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear) state_d = DRAIN;
      DRAIN:   if (count_q == '0) state_d = CLEAR;
      CLEAR:   if (complete && clr_cnt == LAST_ADDR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output logic: next values of the write port, FIFO pop and clear counter.
  // The FIFO count includes the entry currently presented on the write port; it
  // is released only when that write completes.
  always_comb begin
    we_d      = mem_we;
    addr_d    = mem_addr;
    data_d    = mem_data;
    clr_cnt_d = clr_cnt;
    done_d    = 1'b0;
    pop       = 1'b0;
    avail     = complete ? (count_q > CW'(1)) : (count_q != '0);
    rd_sel    = complete ? (rd_ptr + PW'(1)) : rd_ptr;
    case (state_q)
      IDLE, DRAIN: begin
        if (complete) begin
          pop  = 1'b1;
          we_d = 1'b0;
        end
        if ((!mem_we || complete) && avail) begin
          we_d   = 1'b1;
          addr_d = fifo_addr[rd_sel];
          data_d = fifo_data[rd_sel];
        end
        if (state_q == DRAIN && count_q == '0) begin
          we_d      = 1'b1;
          addr_d    = '0;
          data_d    = bg_q;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        if (complete) begin
          if (clr_cnt == LAST_ADDR) begin
            we_d   = 1'b0;
            done_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt + ADDR_W'(1);
            addr_d    = clr_cnt + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
    count_d = count_q + CW'(enq) - CW'(pop);
    busy_d  = (state_d != IDLE) || (count_d == CW'(FIFO_DEPTH));
  end

  // Pixel FIFO storage (no reset needed; validity tracked by count).
  always_ff @(posedge CLOCK_50) begin
    if (enq) begin
      fifo_addr[wr_ptr] <= pix_addr;
      fifo_data[wr_ptr] <= to_depth(VGA_COLOR);
    end
  end

  // Datapath and status registers.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      overflow   <= 1'b0;
      count_q    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      clr_cnt    <= '0;
      bg_q       <= '0;
    end else begin
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_data   <= data_d;
      busy       <= busy_d;
      clear_done <= done_d;
      overflow   <= overflow | (plot && in_range && busy);
      count_q    <= count_d;
      clr_cnt    <= clr_cnt_d;
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (state_q == IDLE && clear) bg_q <= to_depth(bg_color);
    end
  end

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Directed bench for vga_pixel_writer at 160x120, 9-bit colour, 4-entry FIFO.
module tb_vga_pixel_writer;

  localparam int unsigned AW = 15;
  localparam int unsigned CD = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          plot, clear, mem_ready;
  logic [7:0]    vx;
  logic [6:0]    vy;
  logic [23:0]   vcol, bg;
  logic          mem_we, busy, clear_done, overflow;
  logic [AW-1:0] mem_addr;
  logic [CD-1:0] mem_data;

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] wa_q[$];
  logic [CD-1:0] wd_q[$];
  int            done_cnt = 0;

  vga_pixel_writer dut (
    .CLOCK_50(clk), .Resetn(rst_n), .plot(plot), .VGA_X(vx), .VGA_Y(vy),
    .VGA_COLOR(vcol), .clear(clear), .bg_color(bg), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy),
    .clear_done(clear_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Log every write that will complete on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we && mem_ready) begin
        wa_q.push_back(mem_addr);
        wd_q.push_back(mem_data);
      end
      if (clear_done) done_cnt++;
    end
  end

  function automatic logic [CD-1:0] exp_data(input logic [23:0] c);
    return {c[23:21], c[15:13], c[7:5]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; plot = 1'b0; clear = 1'b0; mem_ready = 1'b0;
    vx = '0; vy = '0; vcol = '0; bg = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    wa_q.delete(); wd_q.delete(); done_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; plot = 1'b0; clear = 1'b0; mem_ready = 1'b1;
    vx = '0; vy = '0; vcol = '0; bg = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({mem_we, busy, clear_done, overflow} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags got %b want 0000", {mem_we, busy, clear_done, overflow});
    end
    tests++;
    if (mem_addr !== '0 || mem_data !== '0) begin
      fails++; $display("FAIL reset_bus got addr=%0d data=%h want 0/0", mem_addr, mem_data);
    end
    #1 rst_n = 1'b1;
    repeat (3) step();
    tests++;
    if (mem_we !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_idle got we=%b busy=%b want 0/0", mem_we, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    mem_ready = 1'b1;
    vx = 8'd5; vy = 7'd2; vcol = 24'hFF8040; plot = 1'b1;
    step();
    plot = 1'b0;
    tests++;
    if (mem_we !== 1'b0) begin
      fails++; $display("FAIL single_early got we=%b want 0", mem_we);
    end
    step();
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd325 || mem_data !== 9'b111_100_010) begin
      fails++; $display("FAIL single_write got we=%b addr=%0d data=%b want 1/325/111100010",
                        mem_we, mem_addr, mem_data);
    end
    step();
    tests++;
    if (mem_we !== 1'b0 || wa_q.size() != 1) begin
      fails++; $display("FAIL single_once got we=%b writes=%0d want 0/1", mem_we, wa_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [23:0]   cols [5];
    logic [AW-1:0] addrs [4];
    int            bad;
    cols  = '{24'h123456, 24'hABCDEF, 24'hFFFFFF, 24'h808080, 24'h010101};
    addrs = '{15'd10, 15'd171, 15'd332, 15'd493};
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vx = 8'(10 + i); vy = 7'(i); vcol = cols[i]; plot = 1'b1;
      tests++;
      if (busy !== (i == 4)) begin
        fails++; $display("FAIL ovf_busy[%0d] got %b want %b", i, busy, (i == 4));
      end
      if (i == 4) begin
        tests++;
        if (overflow !== 1'b0) begin
          fails++; $display("FAIL ovf_pre got %b want 0", overflow);
        end
      end
      step();
    end
    plot = 1'b0;
    tests++;
    if (overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_flag got %b want 1", overflow);
    end
    repeat (3) step();
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== addrs[0] || mem_data !== exp_data(cols[0])) begin
      fails++; $display("FAIL ovf_hold got we=%b addr=%0d data=%h want 1/%0d/%h",
                        mem_we, mem_addr, mem_data, addrs[0], exp_data(cols[0]));
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 20 && wa_q.size() < 4; i++) step();
    repeat (3) step();
    tests++;
    if (wa_q.size() != 4) begin
      fails++; $display("FAIL ovf_count got %0d writes want 4", wa_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 4; i++)
        if (wa_q[i] !== addrs[i] || wd_q[i] !== exp_data(cols[i])) bad++;
      tests++;
      if (bad != 0) begin
        fails++; $display("FAIL ovf_order got %0d bad entries want 0", bad);
      end
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    mem_ready = 1'b1;
    vx = 8'd160; vy = 7'd0;   vcol = 24'hFFFFFF; plot = 1'b1; step();
    vx = 8'd0;   vy = 7'd120; step();
    plot = 1'b0;
    repeat (4) step();
    tests++;
    if (wa_q.size() != 0 || overflow !== 1'b0) begin
      fails++; $display("FAIL oor_drop got writes=%0d ovf=%b want 0/0", wa_q.size(), overflow);
    end
    vx = 8'd159; vy = 7'd119; vcol = 24'h20E0A0; plot = 1'b1; step();
    plot = 1'b0;
    step();
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd19199 || mem_data !== 9'b001_111_101) begin
      fails++; $display("FAIL oor_corner got we=%b addr=%0d data=%b want 1/19199/001111101",
                        mem_we, mem_addr, mem_data);
    end
  endtask

  task automatic test_clear(input logic [23:0] bgc);
    int bad;
    do_reset();
    mem_ready = 1'b1;
    vx = 8'd1; vy = 7'd1; vcol = 24'h0000FF; plot = 1'b1; step();
    vx = 8'd2; vcol = 24'hFF0000; clear = 1'b1; bg = bgc; step();
    plot = 1'b0; clear = 1'b0; bg = 24'h5A5A5A;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL clr_busy got %b want 1", busy);
    end
    repeat (5) step();
    vx = 8'd3; vy = 7'd3; plot = 1'b1; clear = 1'b1; step();
    plot = 1'b0; clear = 1'b0;
    tests++;
    if (overflow !== 1'b1) begin
      fails++; $display("FAIL clr_ovf got %b want 1", overflow);
    end
    for (int i = 0; i < 20000 && done_cnt == 0; i++) step();
    repeat (5) step();
    tests++;
    if (done_cnt != 1) begin
      fails++; $display("FAIL clr_done got %0d pulses want 1", done_cnt);
    end
    tests++;
    if (wa_q.size() != 19202) begin
      fails++; $display("FAIL clr_count got %0d writes want 19202", wa_q.size());
    end else begin
      tests++;
      if (wa_q[0] !== 15'd161 || wd_q[0] !== 9'b000_000_111 ||
          wa_q[1] !== 15'd162 || wd_q[1] !== 9'b111_000_000) begin
        fails++; $display("FAIL clr_pix got %0d/%b %0d/%b want 161/000000111 162/111000000",
                          wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
      end
      bad = 0;
      for (int i = 0; i < 19200; i++)
        if (wa_q[i+2] !== AW'(i) || wd_q[i+2] !== exp_data(bgc)) bad++;
      tests++;
      if (bad != 0) begin
        fails++; $display("FAIL clr_fill got %0d bad entries want 0", bad);
      end
    end
    tests++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      fails++; $display("FAIL clr_idle got busy=%b we=%b want 0/0", busy, mem_we);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] ea[$];
    logic [CD-1:0] ed[$];
    int            mcnt, npix, bad;
    logic          ovf_exp, inr, enq, cmp;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [23:0]   c;
    do_reset();
    mcnt = 0; npix = 0; ovf_exp = 1'b0; bad = 0;
    for (int cyc = 0; cyc < 2000 && npix < 200; cyc++) begin
      if (busy !== (mcnt == 4)) bad++;
      mem_ready = 1'($urandom % 2);
      plot = (($urandom % 4) != 0);
      x = 8'($urandom_range(0, 169));
      y = 7'($urandom_range(0, 124));
      c = 24'($urandom);
      vx = x; vy = y; vcol = c;
      if (plot) npix++;
      inr = (x < 8'd160) && (y < 7'd120);
      enq = plot && inr && (mcnt != 4);
      if (plot && inr && mcnt == 4) ovf_exp = 1'b1;
      if (enq) begin
        ea.push_back(AW'(y) * AW'(160) + AW'(x));
        ed.push_back(exp_data(c));
      end
      cmp = mem_we && mem_ready;
      step();
      mcnt = mcnt + int'(enq) - int'(cmp);
    end
    plot = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 100 && wa_q.size() < ea.size(); i++) step();
    repeat (3) step();
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL rnd_busy got %0d busy mismatches want 0", bad);
    end
    tests++;
    if (overflow !== ovf_exp) begin
      fails++; $display("FAIL rnd_ovf got %b want %b", overflow, ovf_exp);
    end
    tests++;
    if (wa_q.size() != ea.size()) begin
      fails++; $display("FAIL rnd_count got %0d writes want %0d", wa_q.size(), ea.size());
    end else begin
      bad = 0;
      for (int i = 0; i < ea.size(); i++)
        if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) bad++;
      tests++;
      if (bad != 0) begin
        fails++; $display("FAIL rnd_order got %0d bad entries want 0", bad);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int waited;
    do_reset();
    mem_ready = 1'b1;
    bg = 24'hFFFFFF; clear = 1'b1; step();
    clear = 1'b0;
    waited = 0;
    while (!(mem_we && mem_addr == 15'd1000) && waited < 2000) begin
      step();
      waited++;
    end
    tests++;
    if (waited >= 2000) begin
      fails++; $display("FAIL rst_mid_reach got addr=%0d want 1000", mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_we, busy, clear_done, overflow} !== 4'b0000 || mem_addr !== '0 || mem_data !== '0) begin
      fails++; $display("FAIL rst_mid_async got we=%b busy=%b addr=%0d data=%h want all 0",
                        mem_we, busy, mem_addr, mem_data);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wa_q.delete(); wd_q.delete(); done_cnt = 0;
    repeat (20) step();
    tests++;
    if (done_cnt != 0 || mem_we !== 1'b0 || busy !== 1'b0 || wa_q.size() != 0) begin
      fails++; $display("FAIL rst_mid_idle got done=%0d we=%b busy=%b writes=%0d want 0/0/0/0",
                        done_cnt, mem_we, busy, wa_q.size());
    end
    vx = 8'd3; vy = 7'd4; vcol = 24'h00FF00; plot = 1'b1; step();
    plot = 1'b0;
    step();
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd643 || mem_data !== 9'b000_111_000) begin
      fails++; $display("FAIL rst_mid_plot got we=%b addr=%0d data=%b want 1/643/000111000",
                        mem_we, mem_addr, mem_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_out_of_range();
    test_clear(24'h000000);
    test_clear(24'hA0C0E0);
    test_random();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
